sha256_stream_padder: RTL

SHA256_STREAM_PADDER -- requirements
Module: sha256_stream_padder

---
 rtl/sha256_stream_padder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sha256_stream_padder.sv
// SHA-256 message padder: packs big-endian input beats into 512-bit blocks and
// appends the 0x80 marker, zero fill and 64-bit bit-length trailer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FILL   | accepting beats into the block buffer
// S_EMIT   | presenting a finished block until the consumer takes it
// S_EXTRA  | building the trailing pad/length-only block of a message
module sha256_stream_padder #(
  parameter  int IN_W   = 32,
  localparam int BCNT_W = $clog2(IN_W/8) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  input  logic [BCNT_W-1:0] in_bytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [511:0]      out_block,
  output logic              out_first,
  output logic              out_last
);

  localparam int BPB    = IN_W / 8;
  localparam int WORDS  = 512 / IN_W;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WORDS - 1);
  localparam logic [BCNT_W-1:0] BPB_C    = BCNT_W'(BPB);

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_EXTRA} state_t;
  typedef enum logic [1:0] {EXT_NONE, EXT_LEN, EXT_PAD} ext_t;

  state_t              state;
  ext_t                ext_kind;
  logic [WCNT_W-1:0]   wcnt;
  logic [60:0]         msg_bytes;   // bytes mod 2^61 == bits mod 2^64
  logic [511:0]        blk;
  logic                first_flag;
  logic                first_q;
  logic                last_q;

  logic [BCNT_W-1:0]   beat_bytes;
  logic [IN_W-1:0]     beat_data;
  logic [6:0]          fill_p;
  logic [60:0]         msg_bytes_nxt;
  logic [511:0]        blk_filled;
  logic [511:0]        blk_padded;
  logic [511:0]        blk_extra;

  always_comb begin
    beat_bytes = BPB_C;
    if (in_last && (in_bytes < BPB_C)) beat_bytes = in_bytes;

    beat_data = '0;
    for (int b = 0; b < BPB; b++) begin
      if (BCNT_W'(b) < beat_bytes) beat_data[IN_W-1-8*b -: 8] = in_data[IN_W-1-8*b -: 8];
    end

    fill_p        = 7'(wcnt) * 7'(BPB) + 7'(beat_bytes);
    msg_bytes_nxt = msg_bytes + 61'(beat_bytes);

    // Unwritten words of blk are always zero, so the pad only has to set bytes.
    blk_filled = blk;
    blk_filled[511 - IN_W*int'(wcnt) -: IN_W] = beat_data;

    blk_padded = blk_filled;
    for (int i = 0; i < 64; i++) begin
      if (fill_p == 7'(i)) blk_padded[511-8*i -: 8] = 8'h80;
    end
    if (fill_p <= 7'd55) blk_padded[63:0] = {msg_bytes_nxt, 3'b000};

    blk_extra = '0;
    if (ext_kind == EXT_PAD) blk_extra[511:504] = 8'h80;
    blk_extra[63:0] = {msg_bytes, 3'b000};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_FILL;
      ext_kind   <= EXT_NONE;
      wcnt       <= '0;
      msg_bytes  <= '0;
      blk        <= '0;
      first_flag <= 1'b1;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_valid) begin
            msg_bytes <= msg_bytes_nxt;
            if (in_last) begin
              blk     <= blk_padded;
              wcnt    <= '0;
              state   <= S_EMIT;
              first_q <= first_flag;
              if (fill_p <= 7'd55) begin
                last_q   <= 1'b1;
                ext_kind <= EXT_NONE;
              end else begin
                last_q   <= 1'b0;
                ext_kind <= (fill_p < 7'd64) ? EXT_LEN : EXT_PAD;
              end
            end else begin
              blk <= blk_filled;
              if (wcnt == WCNT_MAX) begin
                wcnt     <= '0;
                state    <= S_EMIT;
                first_q  <= first_flag;
                last_q   <= 1'b0;
                ext_kind <= EXT_NONE;
              end else begin
                wcnt <= wcnt + 1'b1;
              end
            end
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            blk        <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            first_flag <= last_q;
            if (last_q) msg_bytes <= '0;
            state      <= (ext_kind != EXT_NONE) ? S_EXTRA : S_FILL;
          end
        end

        S_EXTRA: begin
          blk      <= blk_extra;
          first_q  <= 1'b0;
          last_q   <= 1'b1;
          ext_kind <= EXT_NONE;
          state    <= S_EMIT;
        end

        default: state <= S_FILL;
      endcase
    end
  end

  assign in_ready  = (state == S_FILL);
  assign out_valid = (state == S_EMIT);
  assign out_block = blk;
  assign out_first = first_q;
  assign out_last  = last_q;

endmodule
